// File: rtl/ajuste_imagen.sv
// rtl/ajuste_imagen.sv - button-driven brightness/threshold/invert adjust with 2-stage pixel pipeline
module ajuste_imagen #(
    parameter int STEP_BRILLO = 8,
    parameter int STEP_UMBRAL = 8,
    parameter int REPEAT_DLY  = 50_000_000,
    parameter int REPEAT_PER  = 10_000_000,
    parameter int UMBRAL_RST  = 128
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] BOTON_SEL,
    input  logic [7:0] PIX_IN,
    input  logic       PIX_IN_VALID,
    output logic [7:0] PIX_OUT,
    output logic       PIX_BIN,
    output logic       PIX_OUT_VALID,
    output logic [8:0] BRILLO,
    output logic [7:0] UMBRAL,
    output logic       INVERTIDO
);

    // One counter serves both the hold delay and the repeat period
    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]   DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0]   PER_LAST = CNT_W'(REPEAT_PER - 1);
    localparam logic signed [9:0]  SB       = 10'(STEP_BRILLO);
    localparam logic [8:0]         SU9      = 9'(STEP_UMBRAL);
    localparam logic [7:0]         SU8      = 8'(STEP_UMBRAL);
    localparam logic [7:0]         U_RST    = 8'(UMBRAL_RST);

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_B_UP  = 3'd1;
    localparam logic [2:0] C_B_DN  = 3'd2;
    localparam logic [2:0] C_U_UP  = 3'd3;
    localparam logic [2:0] C_U_DN  = 3'd4;
    localparam logic [2:0] C_INV   = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       latch;
    logic [CNT_W-1:0] cnt;

    logic [2:0]        code;
    logic              apply;
    logic signed [9:0] b_ext;
    logic signed [9:0] b_inc;
    logic signed [9:0] b_dec;
    logic [8:0]        b_up_sat;
    logic [8:0]        b_dn_sat;
    logic [8:0]        u_inc;
    logic [7:0]        u_up_sat;
    logic [7:0]        u_dn_sat;

    logic signed [9:0] p_sum;
    logic [7:0]        p_clamp;

    logic [7:0] s1_pix;
    logic [7:0] s1_umbral;
    logic       s1_inv;
    logic       s1_valid;

    // Unused codes 6 and 7 are folded onto "no button"; saturated next values for each action
    always_comb begin
        code     = (BOTON_SEL > C_INV) ? C_NONE : BOTON_SEL;
        apply    = (state == PRESS) ||
                   ((state == REPEAT) && (code == latch) && (cnt == PER_LAST));

        b_ext    = {BRILLO[8], BRILLO};
        b_inc    = b_ext + SB;
        b_dec    = b_ext - SB;
        b_up_sat = (b_inc > 10'sd255)  ? 9'd255  : b_inc[8:0];
        b_dn_sat = (b_dec < -10'sd255) ? 9'h101  : b_dec[8:0];

        u_inc    = {1'b0, UMBRAL} + SU9;
        u_up_sat = (u_inc > 9'd255) ? 8'd255 : u_inc[7:0];
        u_dn_sat = (UMBRAL < SU8)   ? 8'd0   : (UMBRAL - SU8);

        p_sum    = $signed({2'b00, PIX_IN}) + b_ext;
        if (p_sum < 10'sd0) begin
            p_clamp = 8'd0;
        end else if (p_sum > 10'sd255) begin
            p_clamp = 8'd255;
        end else begin
            p_clamp = p_sum[7:0];
        end
    end

    // Button FSM with press/hold/auto-repeat, plus the parameter registers it drives
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            latch     <= C_NONE;
            cnt       <= '0;
            BRILLO    <= 9'd0;
            UMBRAL    <= U_RST;
            INVERTIDO <= 1'b0;
        end else begin
            if (apply) begin
                case (latch)
                    C_B_UP:  BRILLO    <= b_up_sat;
                    C_B_DN:  BRILLO    <= b_dn_sat;
                    C_U_UP:  UMBRAL    <= u_up_sat;
                    C_U_DN:  UMBRAL    <= u_dn_sat;
                    C_INV:   INVERTIDO <= ~INVERTIDO;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (code != C_NONE) begin
                        latch <= code;
                        state <= PRESS;
                    end
                end
                PRESS: begin
                    cnt   <= '0;
                    state <= (code == latch) ? HOLD : IDLE;
                end
                HOLD: begin
                    if (code == C_NONE) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (code != latch) begin
                        cnt   <= '0;
                        latch <= code;
                        state <= PRESS;
                    end else if (cnt == DLY_LAST) begin
                        // Invert parks here with the count frozen until release
                        if (latch != C_INV) begin
                            cnt   <= '0;
                            state <= REPEAT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (code == C_NONE) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (code != latch) begin
                        cnt   <= '0;
                        latch <= code;
                        state <= PRESS;
                    end else if (cnt == PER_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage 1: brightness offset with clamp, snapshot of the parameters the pixel will use
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_pix    <= 8'd0;
            s1_umbral <= 8'd0;
            s1_inv    <= 1'b0;
            s1_valid  <= 1'b0;
        end else begin
            s1_valid <= PIX_IN_VALID;
            if (PIX_IN_VALID) begin
                s1_pix    <= p_clamp;
                s1_umbral <= UMBRAL;
                s1_inv    <= INVERTIDO;
            end
        end
    end

    // Stage 2: optional inversion and thresholding; outputs hold while no pixel is present
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PIX_OUT       <= 8'd0;
            PIX_BIN       <= 1'b0;
            PIX_OUT_VALID <= 1'b0;
        end else begin
            PIX_OUT_VALID <= s1_valid;
            if (s1_valid) begin
                PIX_OUT <= s1_inv ? (8'd255 - s1_pix) : s1_pix;
                PIX_BIN <= (s1_pix >= s1_umbral) ^ s1_inv;
            end
        end
    end

endmodule

// File: tb/tb_ajuste_imagen.sv
// tb/tb_ajuste_imagen.sv - directed self-checking bench for ajuste_imagen
module tb_ajuste_imagen;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] BOTON_SEL;
    logic [7:0] PIX_IN;
    logic       PIX_IN_VALID;
    logic [7:0] PIX_OUT;
    logic       PIX_BIN;
    logic       PIX_OUT_VALID;
    logic [8:0] BRILLO;
    logic [7:0] UMBRAL;
    logic       INVERTIDO;

    int total  = 0;
    int passed = 0;
    int prev_b;
    int bad_dir;

    ajuste_imagen #(
        .STEP_BRILLO(8),
        .STEP_UMBRAL(8),
        .REPEAT_DLY (20),
        .REPEAT_PER (5),
        .UMBRAL_RST (128)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .BOTON_SEL    (BOTON_SEL),
        .PIX_IN       (PIX_IN),
        .PIX_IN_VALID (PIX_IN_VALID),
        .PIX_OUT      (PIX_OUT),
        .PIX_BIN      (PIX_BIN),
        .PIX_OUT_VALID(PIX_OUT_VALID),
        .BRILLO       (BRILLO),
        .UMBRAL       (UMBRAL),
        .INVERTIDO    (INVERTIDO)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic press(input logic [2:0] c);
        BOTON_SEL = c;
        tick(3);
        BOTON_SEL = 3'd0;
        tick(3);
    endtask

    function automatic int br();
        return int'($signed(BRILLO));
    endfunction

    initial begin
        RST = 1'b1;
        BOTON_SEL = 3'd0;
        PIX_IN = 8'd0;
        PIX_IN_VALID = 1'b0;
        tick(2);
        chk("rst_brillo", br(), 0);
        chk("rst_umbral", UMBRAL, 128);
        chk("rst_inv", INVERTIDO, 0);
        chk("rst_pix_out", PIX_OUT, 0);
        chk("rst_pix_bin", PIX_BIN, 0);
        chk("rst_valid", PIX_OUT_VALID, 0);
        RST = 1'b0;
        tick(2);

        // single short press: exactly one step
        press(3'd1);
        chk("t1_brillo", br(), 8);
        chk("t1_umbral", UMBRAL, 128);
        chk("t1_inv", INVERTIDO, 0);

        // held brillo+: press step, hold delay, first repeat, saturation at 255
        BOTON_SEL = 3'd1;
        tick(26);
        chk("t2_before_first_repeat", br(), 16);
        tick(1);
        chk("t2_first_repeat", br(), 24);
        bad_dir = 0;
        prev_b = br();
        for (int i = 0; i < 193; i++) begin
            tick(1);
            if (br() < prev_b) bad_dir = 1;
            prev_b = br();
        end
        chk("t2_up_monotonic", bad_dir, 0);
        chk("t2_sat_pos", br(), 255);
        BOTON_SEL = 3'd0;
        tick(3);

        // held brillo-: saturation at -255
        BOTON_SEL = 3'd2;
        bad_dir = 0;
        prev_b = br();
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (br() > prev_b) bad_dir = 1;
            prev_b = br();
        end
        chk("t2_down_monotonic", bad_dir, 0);
        chk("t2_sat_neg", br(), -255);
        BOTON_SEL = 3'd0;
        tick(3);

        // invert held long: toggles once, never repeats
        BOTON_SEL = 3'd5;
        tick(200);
        chk("t3_inv_held", INVERTIDO, 1);
        BOTON_SEL = 3'd0;
        tick(3);
        chk("t3_inv_released", INVERTIDO, 1);
        press(3'd5);
        chk("t3_inv_second", INVERTIDO, 0);

        // pixel pipeline with brillo=+16
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        press(3'd1);
        press(3'd1);
        chk("t4_brillo16", br(), 16);
        PIX_IN = 8'd250; PIX_IN_VALID = 1'b1;
        tick(1);
        PIX_IN = 8'd100;
        tick(1);
        chk("t4_p0_out", PIX_OUT, 255);
        chk("t4_p0_bin", PIX_BIN, 1);
        chk("t4_p0_valid", PIX_OUT_VALID, 1);
        PIX_IN = 8'd0;
        tick(1);
        chk("t4_p1_out", PIX_OUT, 116);
        chk("t4_p1_bin", PIX_BIN, 0);
        PIX_IN_VALID = 1'b0;
        tick(1);
        chk("t4_p2_out", PIX_OUT, 16);
        chk("t4_p2_bin", PIX_BIN, 0);
        chk("t4_p2_valid", PIX_OUT_VALID, 1);
        tick(1);
        chk("t4_idle_valid", PIX_OUT_VALID, 0);
        chk("t4_idle_hold", PIX_OUT, 16);

        // inverted pixel, then threshold changed while a pixel sits in stage 1
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        press(3'd5);
        PIX_IN = 8'd200; PIX_IN_VALID = 1'b1;
        tick(1);
        PIX_IN_VALID = 1'b0;
        tick(1);
        chk("t5_inv_out", PIX_OUT, 55);
        chk("t5_inv_bin", PIX_BIN, 0);
        BOTON_SEL = 3'd3;
        tick(1);
        PIX_IN = 8'd130; PIX_IN_VALID = 1'b1;
        tick(1);
        BOTON_SEL = 3'd0;
        chk("t5_umbral_new", UMBRAL, 136);
        tick(1);
        chk("t5_old_thr_out", PIX_OUT, 125);
        chk("t5_old_thr_bin", PIX_BIN, 0);
        PIX_IN_VALID = 1'b0;
        tick(1);
        chk("t5_new_thr_bin", PIX_BIN, 1);

        // code change mid-HOLD, then asynchronous reset mid-REPEAT
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        PIX_IN = 8'd100; PIX_IN_VALID = 1'b1;
        BOTON_SEL = 3'd3;
        tick(2);
        chk("t6_umbral_up", UMBRAL, 136);
        tick(3);
        BOTON_SEL = 3'd4;
        tick(1);
        chk("t6_no_extra", UMBRAL, 136);
        tick(1);
        chk("t6_umbral_dn", UMBRAL, 128);
        tick(24);
        chk("t6_before_repeat", UMBRAL, 128);
        tick(1);
        chk("t6_first_repeat", UMBRAL, 120);
        chk("t6_pix_out", PIX_OUT, 100);
        tick(2);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_async_umbral", UMBRAL, 128);
        chk("t6_async_pix_out", PIX_OUT, 0);
        chk("t6_async_valid", PIX_OUT_VALID, 0);
        chk("t6_async_brillo", br(), 0);
        #3;
        RST = 1'b0;
        PIX_IN_VALID = 1'b0;
        tick(1);
        chk("t6_repress_wait", UMBRAL, 128);
        tick(1);
        chk("t6_repress_step", UMBRAL, 120);
        BOTON_SEL = 3'd0;
        tick(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
